// File: rtl/inst_fetch_queue_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect and decode handshake.
// The master modport is the fetch unit's view; the slave modport is the memory/decode side.
interface inst_fetch_queue_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned INST_W = 16
);
  logic              imem_req_valid;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_req_ready;
  logic              imem_resp_valid;
  logic [INST_W-1:0] imem_resp_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              if_valid;
  logic [INST_W-1:0] if_inst;
  logic [ADDR_W-1:0] if_pc;
  logic              if_ready;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc,
    output if_valid, if_inst, if_pc,
    input  if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc,
    input  if_valid, if_inst, if_pc,
    output if_ready
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: fetch PC, credit-limited imem requests, in-order prefetch
// queue of {inst, pc} toward decode, and redirect (flush + restart).
// Optional feature macro: FETCH_STALL_CNT_EN adds the saturating stall_cnt output.
module inst_fetch_queue #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned INST_W   = 16,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic        clk,
  input  logic        rst,
  inst_fetch_queue_if.master bus
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 2;

  // Fetch PC and credit counters (queued, in flight, to be discarded).
  logic [ADDR_W-1:0] r_fpc;
  logic [CNT_W-1:0]  r_occ;
  logic [CNT_W-1:0]  r_out;
  logic [CNT_W-1:0]  r_drop;

  // Prefetch queue storage and pointers.
  logic [INST_W-1:0] r_q_inst [DEPTH];
  logic [ADDR_W-1:0] r_q_pc   [DEPTH];
  logic [PTR_W-1:0]  r_q_rd;
  logic [PTR_W-1:0]  r_q_wr;

  // PCs of live in-flight requests, oldest first.
  logic [ADDR_W-1:0] r_pf_pc [DEPTH];
  logic [PTR_W-1:0]  r_pf_rd;
  logic [PTR_W-1:0]  r_pf_wr;

  logic [SUM_W-1:0]  w_sum;
  logic              w_req_valid;
  logic              w_accept;
  logic              w_resp_hit;
  logic              w_resp_drop;
  logic              w_resp_keep;
  logic              w_enq;
  logic              w_if_valid;
  logic              w_deq;

  assign w_sum       = SUM_W'(r_occ) + SUM_W'(r_out) + SUM_W'(r_drop);
  assign w_req_valid = !rst && !bus.redirect_valid && (w_sum < SUM_W'(DEPTH));
  assign w_accept    = w_req_valid && bus.imem_req_ready;
  // A response is either owed to a flushed request (drop) or to a live one (keep).
  assign w_resp_drop = bus.imem_resp_valid && (r_drop != '0);
  assign w_resp_keep = bus.imem_resp_valid && (r_drop == '0) && (r_out != '0);
  assign w_resp_hit  = w_resp_drop || w_resp_keep;
  assign w_enq       = !rst && !bus.redirect_valid && w_resp_keep;
  assign w_if_valid  = (r_occ != '0);
  assign w_deq       = w_if_valid && bus.if_ready;

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_fpc;
  assign bus.if_valid       = w_if_valid;
  assign bus.if_inst        = w_if_valid ? r_q_inst[r_q_rd] : '0;
  assign bus.if_pc          = w_if_valid ? r_q_pc[r_q_rd]   : '0;

  // Control state: PC, counters and pointers; redirect flushes and moves debt to drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fpc   <= ADDR_W'(RESET_PC);
      r_occ   <= '0;
      r_out   <= '0;
      r_drop  <= '0;
      r_q_rd  <= '0;
      r_q_wr  <= '0;
      r_pf_rd <= '0;
      r_pf_wr <= '0;
    end else if (bus.redirect_valid) begin
      r_fpc   <= bus.redirect_pc;
      r_occ   <= '0;
      r_out   <= '0;
      r_drop  <= r_drop + r_out - CNT_W'(w_resp_hit);
      r_q_rd  <= '0;
      r_q_wr  <= '0;
      r_pf_rd <= '0;
      r_pf_wr <= '0;
    end else begin
      if (w_accept) begin
        r_fpc   <= r_fpc + ADDR_W'(1);
        r_pf_wr <= r_pf_wr + PTR_W'(1);
      end
      if (w_resp_keep) begin
        r_pf_rd <= r_pf_rd + PTR_W'(1);
        r_q_wr  <= r_q_wr + PTR_W'(1);
      end
      if (w_deq) begin
        r_q_rd <= r_q_rd + PTR_W'(1);
      end
      r_out  <= r_out + CNT_W'(w_accept) - CNT_W'(w_resp_keep);
      r_drop <= r_drop - CNT_W'(w_resp_drop);
      r_occ  <= r_occ + CNT_W'(w_enq) - CNT_W'(w_deq);
    end
  end

  // Storage writes: capture request PC at accept, {data, pc} at live response.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_pf_pc[r_pf_wr] <= r_fpc;
    end
    if (w_enq) begin
      r_q_inst[r_q_wr] <= bus.imem_resp_data;
      r_q_pc[r_q_wr]   <= r_pf_pc[r_pf_rd];
    end
  end

`ifndef SYNTHESIS
  // Flag a response the memory had no outstanding request for.
  always_ff @(posedge clk) begin
    if (!rst && bus.imem_resp_valid && (r_out == '0) && (r_drop == '0)) begin
      $error("inst_fetch_queue: unexpected imem response");
    end
  end
`endif

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] r_stall;

  // Count cycles with nothing to offer decode; saturate, clear only on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall <= '0;
    end else if (!w_if_valid && (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign stall_cnt = r_stall;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with an in-order, fixed-latency memory model.
// Build with FETCH_STALL_CNT_EN defined to also exercise the stall counter.
module tb_inst_fetch_queue;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_fetch_queue_if #(.ADDR_W(16), .INST_W(16)) bus ();

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  inst_fetch_queue #(
    .ADDR_W(16), .INST_W(16), .DEPTH(4), .RESET_PC(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  int nvec = 0;
  int nerr = 0;
  int lat  = 1;
  int cyc  = 0;
  int n_acc = 0;
  int n_deq = 0;
  logic [15:0] last_deq_pc;
  logic [15:0] pq_addr [$];
  int          pq_due  [$];

  function automatic logic [15:0] memf(input logic [15:0] a);
    return a ^ 16'hC35A;
  endfunction

  // Memory model bookkeeping and decode-transfer monitor, sampled at the edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      pq_addr.delete();
      pq_due.delete();
      n_acc = 0;
      n_deq = 0;
    end else begin
      if (bus.imem_resp_valid) begin
        void'(pq_addr.pop_front());
        void'(pq_due.pop_front());
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        pq_addr.push_back(bus.imem_req_addr);
        pq_due.push_back(cyc + lat);
        n_acc = n_acc + 1;
      end
      if (bus.if_valid && bus.if_ready) begin
        n_deq = n_deq + 1;
        last_deq_pc = bus.if_pc;
      end
    end
  end

  // Present the oldest response once its latency has elapsed.
  always @(negedge clk) begin
    if (pq_addr.size() > 0 && pq_due[0] <= cyc + 1) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = memf(pq_addr[0]);
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 16'h0000;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.imem_req_ready = 1'b1;
    bus.if_ready = 1'b1;
    apply_reset();
    rst = 1'b1;
    tick();
    tick();
    nvec++; if (bus.imem_req_valid !== 1'b0) begin nerr++; $display("FAIL reset_req_valid got=%b exp=0", bus.imem_req_valid); end
    nvec++; if (bus.if_valid !== 1'b0) begin nerr++; $display("FAIL reset_if_valid got=%b exp=0", bus.if_valid); end
    nvec++; if (bus.if_inst !== 16'h0000) begin nerr++; $display("FAIL reset_if_inst got=%h exp=0000", bus.if_inst); end
    nvec++; if (bus.if_pc !== 16'h0000) begin nerr++; $display("FAIL reset_if_pc got=%h exp=0000", bus.if_pc); end
    rst = 1'b0;
    #1;
    nvec++; if (bus.imem_req_valid !== 1'b1) begin nerr++; $display("FAIL post_reset_req_valid got=%b exp=1", bus.imem_req_valid); end
    nvec++; if (bus.imem_req_addr !== 16'h0000) begin nerr++; $display("FAIL post_reset_addr got=%h exp=0000", bus.imem_req_addr); end
  endtask

  task automatic test_stream();
    lat = 1;
    bus.imem_req_ready = 1'b1;
    bus.if_ready = 1'b1;
    apply_reset();
    tick();
    nvec++; if (bus.if_valid !== 1'b0) begin nerr++; $display("FAIL stream_early_valid got=%b exp=0", bus.if_valid); end
    nvec++; if (bus.imem_req_addr !== 16'h0001) begin nerr++; $display("FAIL stream_addr1 got=%h exp=0001", bus.imem_req_addr); end
    tick();
    nvec++; if (bus.if_valid !== 1'b1) begin nerr++; $display("FAIL stream_first_valid got=%b exp=1", bus.if_valid); end
    nvec++; if (bus.if_pc !== 16'h0000) begin nerr++; $display("FAIL stream_first_pc got=%h exp=0000", bus.if_pc); end
    nvec++; if (bus.if_inst !== memf(16'h0000)) begin nerr++; $display("FAIL stream_first_inst got=%h exp=%h", bus.if_inst, memf(16'h0000)); end
    for (int i = 1; i <= 5; i++) begin
      tick();
      nvec++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 16'(i)) begin nerr++; $display("FAIL stream_pc got=%b/%h exp=1/%h", bus.if_valid, bus.if_pc, 16'(i)); end
      nvec++; if (bus.if_inst !== memf(16'(i))) begin nerr++; $display("FAIL stream_inst got=%h exp=%h", bus.if_inst, memf(16'(i))); end
      nvec++; if (bus.imem_req_addr !== 16'(i + 2)) begin nerr++; $display("FAIL stream_addr got=%h exp=%h", bus.imem_req_addr, 16'(i + 2)); end
    end
  endtask

  task automatic test_full();
    lat = 1;
    bus.imem_req_ready = 1'b1;
    bus.if_ready = 1'b0;
    apply_reset();
    for (int i = 0; i < 6; i++) tick();
    nvec++; if (n_acc !== 4) begin nerr++; $display("FAIL full_accepts got=%0d exp=4", n_acc); end
    nvec++; if (bus.imem_req_valid !== 1'b0) begin nerr++; $display("FAIL full_req_valid got=%b exp=0", bus.imem_req_valid); end
    nvec++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 16'h0000) begin nerr++; $display("FAIL full_head got=%b/%h exp=1/0000", bus.if_valid, bus.if_pc); end
    bus.if_ready = 1'b1;
    tick();
    bus.if_ready = 1'b0;
    nvec++; if (bus.if_pc !== 16'h0001) begin nerr++; $display("FAIL full_next_pc got=%h exp=0001", bus.if_pc); end
    nvec++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 16'h0004) begin nerr++; $display("FAIL full_reissue got=%b/%h exp=1/0004", bus.imem_req_valid, bus.imem_req_addr); end
    tick();
    nvec++; if (bus.if_pc !== 16'h0001 || bus.if_inst !== memf(16'h0001)) begin nerr++; $display("FAIL full_hold got=%h/%h exp=0001/%h", bus.if_pc, bus.if_inst, memf(16'h0001)); end
    nvec++; if (n_acc !== 5 || bus.imem_req_valid !== 1'b0) begin nerr++; $display("FAIL full_one_new got=%0d/%b exp=5/0", n_acc, bus.imem_req_valid); end
    nvec++; if (n_deq !== 1) begin nerr++; $display("FAIL full_deq_count got=%0d exp=1", n_deq); end
  endtask

  task automatic test_redirect();
    lat = 3;
    bus.imem_req_ready = 1'b1;
    bus.if_ready = 1'b1;
    apply_reset();
    tick(); tick(); tick();
    nvec++; if (n_acc !== 3) begin nerr++; $display("FAIL redir_inflight got=%0d exp=3", n_acc); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 16'h0040;
    #1;
    nvec++; if (bus.imem_req_valid !== 1'b0) begin nerr++; $display("FAIL redir_no_req got=%b exp=0", bus.imem_req_valid); end
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    nvec++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 16'h0040) begin nerr++; $display("FAIL redir_new_req got=%b/%h exp=1/0040", bus.imem_req_valid, bus.imem_req_addr); end
    tick(); tick(); tick();
    nvec++; if (bus.if_valid !== 1'b0) begin nerr++; $display("FAIL redir_stale_drop got=%b exp=0", bus.if_valid); end
    nvec++; if (n_acc !== 6) begin nerr++; $display("FAIL redir_accepts got=%0d exp=6", n_acc); end
    tick();
    nvec++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 16'h0040) begin nerr++; $display("FAIL redir_head_pc got=%b/%h exp=1/0040", bus.if_valid, bus.if_pc); end
    nvec++; if (bus.if_inst !== memf(16'h0040)) begin nerr++; $display("FAIL redir_head_inst got=%h exp=%h", bus.if_inst, memf(16'h0040)); end
    tick();
    nvec++; if (bus.if_pc !== 16'h0041) begin nerr++; $display("FAIL redir_next_pc got=%h exp=0041", bus.if_pc); end
  endtask

  task automatic test_wrap();
    lat = 1;
    bus.imem_req_ready = 1'b1;
    bus.if_ready = 1'b1;
    apply_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 16'hFFFE;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    nvec++; if (bus.imem_req_addr !== 16'hFFFE) begin nerr++; $display("FAIL wrap_addr0 got=%h exp=fffe", bus.imem_req_addr); end
    tick();
    nvec++; if (bus.imem_req_addr !== 16'hFFFF) begin nerr++; $display("FAIL wrap_addr1 got=%h exp=ffff", bus.imem_req_addr); end
    tick();
    nvec++; if (bus.imem_req_addr !== 16'h0000) begin nerr++; $display("FAIL wrap_addr2 got=%h exp=0000", bus.imem_req_addr); end
    nvec++; if (bus.if_pc !== 16'hFFFE) begin nerr++; $display("FAIL wrap_pc0 got=%h exp=fffe", bus.if_pc); end
    tick();
    nvec++; if (bus.if_pc !== 16'hFFFF || bus.if_inst !== memf(16'hFFFF)) begin nerr++; $display("FAIL wrap_pc1 got=%h/%h exp=ffff/%h", bus.if_pc, bus.if_inst, memf(16'hFFFF)); end
    tick();
    nvec++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 16'h0000) begin nerr++; $display("FAIL wrap_pc2 got=%b/%h exp=1/0000", bus.if_valid, bus.if_pc); end
  endtask

  task automatic test_redirect_handshake();
    lat = 1;
    bus.imem_req_ready = 1'b1;
    bus.if_ready = 1'b1;
    apply_reset();
    tick(); tick();
    nvec++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 16'h0000) begin nerr++; $display("FAIL rh_pre_head got=%b/%h exp=1/0000", bus.if_valid, bus.if_pc); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 16'h0100;
    #1;
    nvec++; if (bus.imem_req_valid !== 1'b0) begin nerr++; $display("FAIL rh_no_req got=%b exp=0", bus.imem_req_valid); end
    tick();
    bus.redirect_valid = 1'b0;
    nvec++; if (bus.if_valid !== 1'b0) begin nerr++; $display("FAIL rh_empty got=%b exp=0", bus.if_valid); end
    nvec++; if (n_deq !== 1 || last_deq_pc !== 16'h0000) begin nerr++; $display("FAIL rh_consumed got=%0d/%h exp=1/0000", n_deq, last_deq_pc); end
    nvec++; if (n_acc !== 2) begin nerr++; $display("FAIL rh_accepts got=%0d exp=2", n_acc); end
    tick(); tick();
    nvec++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 16'h0100) begin nerr++; $display("FAIL rh_new_head got=%b/%h exp=1/0100", bus.if_valid, bus.if_pc); end
    nvec++; if (n_deq !== 1) begin nerr++; $display("FAIL rh_once got=%0d exp=1", n_deq); end
  endtask

`ifdef FETCH_STALL_CNT_EN
  task automatic test_stall();
    lat = 5;
    bus.imem_req_ready = 1'b1;
    bus.if_ready = 1'b1;
    apply_reset();
    nvec++; if (stall_cnt !== 16'h0000) begin nerr++; $display("FAIL stall_reset got=%h exp=0000", stall_cnt); end
    for (int i = 0; i < 6; i++) tick();
    nvec++; if (stall_cnt !== 16'd6) begin nerr++; $display("FAIL stall_empty got=%0d exp=6", stall_cnt); end
    nvec++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 16'h0000) begin nerr++; $display("FAIL stall_head got=%b/%h exp=1/0000", bus.if_valid, bus.if_pc); end
    tick(); tick(); tick();
    nvec++; if (stall_cnt !== 16'd6 || bus.if_valid !== 1'b1) begin nerr++; $display("FAIL stall_hold got=%0d/%b exp=6/1", stall_cnt, bus.if_valid); end
    rst = 1'b1;
    tick();
    nvec++; if (stall_cnt !== 16'h0000 || bus.if_valid !== 1'b0) begin nerr++; $display("FAIL stall_midrst got=%h/%b exp=0000/0", stall_cnt, bus.if_valid); end
    rst = 1'b0;
    #1;
    nvec++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 16'h0000) begin nerr++; $display("FAIL stall_fpc got=%b/%h exp=1/0000", bus.imem_req_valid, bus.imem_req_addr); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 16'h0000;
    bus.if_ready = 1'b0;
    test_reset();
    test_stream();
    test_full();
    test_redirect();
    test_wrap();
    test_redirect_handshake();
`ifdef FETCH_STALL_CNT_EN
    test_stall();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
